// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: start/duration/done link between the phase
// sequencer (master) and its countdown timer (slave).
interface traffic_phase_ctrl_if;
  logic       tmr_start;
  logic [7:0] tmr_duration;
  logic       tmr_done;

  modport master (
    output tmr_start,
    output tmr_duration,
    input  tmr_done
  );

  modport slave (
    input  tmr_start,
    input  tmr_duration,
    output tmr_done
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road intersection phase sequencer with ped walk.
// Define TLC_FLASH_EN to add the flash_req port and yellow flash mode.
module traffic_phase_ctrl #(
  parameter logic [7:0] T_GREEN  = 8'd20,
  parameter logic [7:0] T_YELLOW = 8'd4,
  parameter logic [7:0] T_ALLRED = 8'd2,
  parameter logic [7:0] T_WALK   = 8'd10
`ifdef TLC_FLASH_EN
  ,parameter logic [7:0] FLASH_HALF = 8'd8
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ped_req,
`ifdef TLC_FLASH_EN
  input  logic                        flash_req,
`endif
  traffic_phase_ctrl_if.master        tmr,
  output logic [2:0]                  ns_light,
  output logic [2:0]                  ew_light,
  output logic                        walk,
  output logic [2:0]                  phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } phase_e;

  // The timer never gets a zero load.
  localparam logic [7:0] D_G =
    (T_GREEN == 8'd0) ? 8'd1 : T_GREEN;
  localparam logic [7:0] D_Y =
    (T_YELLOW == 8'd0) ? 8'd1 : T_YELLOW;
  localparam logic [7:0] D_A =
    (T_ALLRED == 8'd0) ? 8'd1 : T_ALLRED;
  localparam logic [7:0] D_W =
    (T_WALK == 8'd0) ? 8'd1 : T_WALK;

  phase_e     ph;
  phase_e     nxt;
  logic       run;
  logic       pend;
  logic       ret_ew;
  logic       done_seen;
  logic       enter_walk;
  logic [7:0] dur;

`ifdef TLC_FLASH_EN
  localparam logic [7:0] F_HALF =
    (FLASH_HALF == 8'd0) ? 8'd1 : FLASH_HALF;
  logic [7:0] fcnt;
  logic       fon;
`endif

  assign done_seen  = run & tmr.tmr_done;
  assign enter_walk = done_seen & (nxt == PED_WALK);

  always_comb begin
    nxt = ALLRED_B;
    unique case (ph)
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = ALLRED_A;
      ALLRED_A:  nxt = pend ? PED_WALK : EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_YELLOW: nxt = ALLRED_B;
      ALLRED_B:  nxt = pend ? PED_WALK : NS_GREEN;
      PED_WALK:  nxt = ret_ew ? EW_GREEN : NS_GREEN;
      default:   nxt = ALLRED_B;
    endcase
`ifdef TLC_FLASH_EN
    if (flash_req) nxt = FLASH;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= ALLRED_B;
      run    <= 1'b0;
      pend   <= 1'b0;
      ret_ew <= 1'b0;
`ifdef TLC_FLASH_EN
      fcnt   <= 8'd0;
      fon    <= 1'b1;
`endif
    end else begin
      pend <= ped_req | (pend & ~enter_walk);
`ifdef TLC_FLASH_EN
      if (ph == FLASH) begin
        if (fcnt == F_HALF - 8'd1) begin
          fcnt <= 8'd0;
          fon  <= ~fon;
        end else begin
          fcnt <= fcnt + 8'd1;
        end
        if (!flash_req) begin
          ph  <= ALLRED_B;
          run <= 1'b0;
        end
      end else
`endif
      if (!run) begin
        run <= 1'b1;
      end else if (tmr.tmr_done) begin
        ph  <= nxt;
        run <= 1'b0;
        if (nxt == PED_WALK) ret_ew <= (ph == ALLRED_A);
`ifdef TLC_FLASH_EN
        fcnt <= 8'd0;
        fon  <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    unique case (ph)
      NS_GREEN, EW_GREEN:   dur = D_G;
      NS_YELLOW, EW_YELLOW: dur = D_Y;
      PED_WALK:             dur = D_W;
      default:              dur = D_A;
    endcase
  end

  // RUN drops start once done is seen so the timer parks at zero.
  assign tmr.tmr_duration = dur;
  assign tmr.tmr_start    =
    (ph != FLASH) & (~run | ~tmr.tmr_done);
  assign phase = ph;

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    walk     = 1'b0;
    unique case (ph)
      NS_GREEN:  ns_light = 3'b001;
      NS_YELLOW: ns_light = 3'b010;
      EW_GREEN:  ew_light = 3'b001;
      EW_YELLOW: ew_light = 3'b010;
      PED_WALK:  walk     = 1'b1;
`ifdef TLC_FLASH_EN
      FLASH: begin
        ns_light = fon ? 3'b010 : 3'b000;
        ew_light = fon ? 3'b010 : 3'b000;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: vector tables, corner sequences and a random
// run against a phase-level reference model; two DUTs (default, T_YELLOW=0).
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       ped_req;
  logic [2:0] ns0, ew0, ph0;
  logic [2:0] ns1, ew1, ph1;
  logic       walk0, walk1;
  logic [7:0] cnt0, cnt1;
  bit         rnd_on;
  int         checks;
  int         failures;
`ifdef TLC_FLASH_EN
  logic       flash_req;
`endif

  traffic_phase_ctrl_if tif0 ();
  traffic_phase_ctrl_if tif1 ();

  traffic_phase_ctrl dut0 (
    .clk      (clk),
    .rst      (rst),
    .ped_req  (ped_req),
`ifdef TLC_FLASH_EN
    .flash_req(flash_req),
`endif
    .tmr      (tif0),
    .ns_light (ns0),
    .ew_light (ew0),
    .walk     (walk0),
    .phase    (ph0)
  );

  traffic_phase_ctrl #(.T_YELLOW(8'd0)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .ped_req  (ped_req),
`ifdef TLC_FLASH_EN
    .flash_req(flash_req),
`endif
    .tmr      (tif1),
    .ns_light (ns1),
    .ew_light (ew1),
    .walk     (walk1),
    .phase    (ph1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Countdown timers: load on start when idle at zero, else count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt0 <= 8'd0;
    else if (tif0.tmr_start)
      cnt0 <= (cnt0 == 8'd0) ? tif0.tmr_duration : cnt0 - 8'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt1 <= 8'd0;
    else if (tif1.tmr_start)
      cnt1 <= (cnt1 == 8'd0) ? tif1.tmr_duration : cnt1 - 8'd1;
  end
  assign tif0.tmr_done = (cnt0 == 8'd0);
  assign tif1.tmr_done = (cnt1 == 8'd0);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Safety: outside flash, never two non-red roads, lamps one-hot.
  always @(negedge clk) begin
    if (ph0 != 3'd7) begin
      checks++;
      if ((ns0 != 3'b100 && ew0 != 3'b100) ||
          !$onehot(ns0) || !$onehot(ew0)) begin
        failures++;
        $display("FAIL safety0: ns %b ew %b", ns0, ew0);
      end
    end
    if (ph1 != 3'd7) begin
      checks++;
      if ((ns1 != 3'b100 && ew1 != 3'b100) ||
          !$onehot(ns1) || !$onehot(ew1)) begin
        failures++;
        $display("FAIL safety1: ns %b ew %b", ns1, ew1);
      end
    end
  end

  // Phase-level model: each phase lasts dur+2 cycles, then picks a successor.
  typedef struct {
    int ph;
    int left;
    bit pend;
    int ret;
  } mstate_t;

  function automatic int mdur(int p, int ty);
    int d;
    case (p)
      0, 3:    d = 20;
      1, 4:    d = ty;
      6:       d = 10;
      default: d = 2;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

  function automatic mstate_t mreset(int ty);
    mstate_t s;
    s.ph   = 5;
    s.left = mdur(5, ty) + 2;
    s.pend = 1'b0;
    s.ret  = 0;
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, bit ped, int ty);
    mstate_t n;
    n      = s;
    n.pend = s.pend | ped;
    if (s.left > 1) begin
      n.left = s.left - 1;
    end else begin
      case (s.ph)
        0:       n.ph = 1;
        1:       n.ph = 2;
        2:       n.ph = s.pend ? 6 : 3;
        3:       n.ph = 4;
        4:       n.ph = 5;
        5:       n.ph = s.pend ? 6 : 0;
        default: n.ph = s.ret;
      endcase
      if (n.ph == 6) begin
        n.ret = (s.ph == 2) ? 3 : 0;
        if (!ped) n.pend = 1'b0;
      end
      n.left = mdur(n.ph, ty) + 2;
    end
    return n;
  endfunction

  function automatic logic [2:0] mns(int p);
    return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] mew(int p);
    return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
  endfunction

  mstate_t m0, m1;

  always @(posedge clk) begin
    if (rst) begin
      m0 = mreset(4);
      m1 = mreset(0);
    end else begin
      m0 = mstep(m0, ped_req, 4);
      m1 = mstep(m1, ped_req, 0);
    end
  end

  task automatic cmp_model(input string tag, input mstate_t m,
                           input int ty, input logic [2:0] p,
                           input logic [2:0] ns, input logic [2:0] ew,
                           input logic wk, input logic st,
                           input logic [7:0] du);
    chk({tag, ".phase"}, p, m.ph);
    chk({tag, ".dur"}, du, mdur(m.ph, ty));
    chk({tag, ".start"}, st, (m.left != 1));
    chk({tag, ".ns"}, ns, mns(m.ph));
    chk({tag, ".ew"}, ew, mew(m.ph));
    chk({tag, ".walk"}, wk, (m.ph == 6));
  endtask

  // Called from a point just after a rising edge; checks async reset.
  task automatic do_reset();
    ped_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst.phase", ph0, 3'd5);
    chk("rst.ns", ns0, 3'b100);
    chk("rst.ew", ew0, 3'b100);
    chk("rst.walk", walk0, 1'b0);
    chk("rst.start", tif0.tmr_start, 1'b1);
    chk("rst.dur", tif0.tmr_duration, 8'd2);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit rst;
    int n;
    bit ped;
    int ph;
    int dur;
    bit walk;
  } vec_t;

  function automatic vec_t v(bit r, int n, bit p, int ph, int d, bit w);
    vec_t x;
    x.rst  = r;
    x.n    = n;
    x.ped  = p;
    x.ph   = ph;
    x.dur  = d;
    x.walk = w;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    checks   = 0;
    failures = 0;
    rnd_on   = 1'b0;
    rst      = 1'b1;
    ped_req  = 1'b0;
`ifdef TLC_FLASH_EN
    flash_req = 1'b0;
`endif
    // Plain cycle from reset release.
    tbl.push_back(v(1, 4, 0, 5, 2, 0));
    tbl.push_back(v(0, 22, 0, 0, 20, 0));
    tbl.push_back(v(0, 6, 0, 1, 4, 0));
    tbl.push_back(v(0, 4, 0, 2, 2, 0));
    tbl.push_back(v(0, 5, 0, 3, 20, 0));
    // Ped pulse in NS_GREEN; reset lands mid EW_GREEN.
    tbl.push_back(v(1, 4, 0, 5, 2, 0));
    tbl.push_back(v(0, 1, 1, 0, 20, 0));
    tbl.push_back(v(0, 21, 0, 0, 20, 0));
    tbl.push_back(v(0, 6, 0, 1, 4, 0));
    tbl.push_back(v(0, 4, 0, 2, 2, 0));
    tbl.push_back(v(0, 12, 0, 6, 10, 1));
    tbl.push_back(v(0, 22, 0, 3, 20, 0));
    tbl.push_back(v(0, 6, 0, 4, 4, 0));
    tbl.push_back(v(0, 4, 0, 5, 2, 0));
    tbl.push_back(v(0, 2, 0, 0, 20, 0));
    // Request coincides with entry to walk: second walk after ALLRED_B.
    tbl.push_back(v(1, 4, 0, 5, 2, 0));
    tbl.push_back(v(0, 1, 1, 0, 20, 0));
    tbl.push_back(v(0, 21, 0, 0, 20, 0));
    tbl.push_back(v(0, 6, 0, 1, 4, 0));
    tbl.push_back(v(0, 3, 0, 2, 2, 0));
    tbl.push_back(v(0, 1, 1, 2, 2, 0));
    tbl.push_back(v(0, 12, 0, 6, 10, 1));
    tbl.push_back(v(0, 22, 0, 3, 20, 0));
    tbl.push_back(v(0, 6, 0, 4, 4, 0));
    tbl.push_back(v(0, 4, 0, 5, 2, 0));
    tbl.push_back(v(0, 12, 0, 6, 10, 1));
    tbl.push_back(v(0, 22, 0, 0, 20, 0));
    tbl.push_back(v(0, 1, 0, 1, 4, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      for (int c = 0; c < tbl[i].n; c++) begin
        ped_req = tbl[i].ped;
        @(negedge clk);
        chk($sformatf("tbl%0d.phase", i), ph0, tbl[i].ph);
        chk($sformatf("tbl%0d.dur", i), tif0.tmr_duration, tbl[i].dur);
        chk($sformatf("tbl%0d.walk", i), walk0, tbl[i].walk);
        @(posedge clk);
        #1;
      end
    end

    // T_YELLOW=0: yellow is clamped to 1 and lasts 3 cycles.
    do_reset();
    for (int k = 0; k < 31; k++) begin
      int e;
      e = (k < 4) ? 5 : (k < 26) ? 0 : (k < 29) ? 1 : 2;
      @(negedge clk);
      chk($sformatf("ty0.phase@%0d", k), ph1, e);
      if (e == 1) chk("ty0.dur", tif1.tmr_duration, 8'd1);
      @(posedge clk);
      #1;
    end

`ifdef TLC_FLASH_EN
    begin
      int w;
      do_reset();
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
      end
      flash_req = 1'b1;
      w = 0;
      @(negedge clk);
      while (ph0 != 3'd7 && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("flash.entry", ph0, 3'd7);
      for (int k = 0; k < 24; k++) begin
        logic [2:0] el;
        el = ((k / 8) % 2 == 0) ? 3'b010 : 3'b000;
        chk($sformatf("flash.ns@%0d", k), ns0, el);
        chk($sformatf("flash.ew@%0d", k), ew0, el);
        chk("flash.start", tif0.tmr_start, 1'b0);
        chk("flash.walk", walk0, 1'b0);
        @(negedge clk);
      end
      flash_req = 1'b0;
      @(negedge clk);
      chk("unflash.phase", ph0, 3'd5);
      chk("unflash.start", tif0.tmr_start, 1'b1);
      chk("unflash.dur", tif0.tmr_duration, 8'd2);
      @(negedge clk);
      chk("unflash.cnt", cnt0, 8'd2);
      @(posedge clk);
      #1;
    end
`endif

    // Random pedestrian traffic against the phase-level model.
    do_reset();
    rnd_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      ped_req = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      cmp_model("rnd0", m0, 4, ph0, ns0, ew0, walk0,
                tif0.tmr_start, tif0.tmr_duration);
      cmp_model("rnd1", m1, 0, ph1, ns1, ew1, walk1,
                tif1.tmr_start, tif1.tmr_duration);
      @(posedge clk);
      #1;
    end
    rnd_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name:
traffic_phase_ctrl

Overview:
- Phase sequencer for a two-road intersection with a pedestrian crossing.
- Sits directly upstream of the countdown timer. It drives the timer's start and duration inputs and consumes its done output.
- Advances through the light phases and decodes the lamp outputs from the current phase.

Parameters:
- T_GREEN, 8'd20: green phase duration in timer ticks
- T_YELLOW, 8'd4: yellow phase duration
- T_ALLRED, 8'd2: all-red clearance duration
- T_WALK, 8'd10: pedestrian walk duration
- FLASH_HALF, 8'd8: half-period of flash mode in clk cycles (used only with the macro)

Ports:
- clk, input, 1: clock
- rst, input, 1: reset, asynchronous, active-high
- ped_req, input, 1: pedestrian request; single-cycle pulse or level
- tmr_done, input, 1: timer done level
- tmr_start, output, 1: timer enable/start
- tmr_duration, output, 8: timer load value
- ns_light, output, 3: north-south lamps {red,yellow,green}, one-hot
- ew_light, output, 3: east-west lamps {red,yellow,green}, one-hot
- walk, output, 1: pedestrian walk lamp
- phase, output, 3: current phase code
- flash_req, input, 1: flash-mode request; port exists only with TLC_FLASH_EN

Behaviour:
- Phase codes:
  - 0 NS_GREEN
  - 1 NS_YELLOW
  - 2 ALLRED_A
  - 3 EW_GREEN
  - 4 EW_YELLOW
  - 5 ALLRED_B
  - 6 PED_WALK
  - 7 FLASH (only with the macro)
- Sequence: 0→1→2→3→4→5→0.
- If ped_pending=1 when leaving ALLRED_A or ALLRED_B, go to PED_WALK instead of the next phase.
  - PED_WALK then continues to EW_GREEN (after A) or NS_GREEN (after B).
  - The return target is held in a 1-bit register.
- Sub-state per phase: LOAD or RUN.
  - LOAD: tmr_start=1 and tmr_duration=duration of the current phase. Always lasts 1 cycle, then goes to RUN. tmr_done is ignored in LOAD.
  - RUN: tmr_start = ~tmr_done, combinational, so the timer holds at 0 instead of reloading the old duration. When tmr_done=1 is seen in RUN: phase ← next phase, sub-state ← LOAD.
- tmr_duration is a combinational decode of the phase register. It is stable during LOAD and RUN.
- Duration clamp: any parameter value of 0 is driven as 1. The timer never reloads 0.
- Phase length is D+2 cycles: 1 LOAD cycle, D counting cycles, 1 done-seen cycle.
- Lamp decode depends on the phase register only:
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
  - ALLRED_A, ALLRED_B, PED_WALK: ns=100, ew=100
  - walk=1 only in PED_WALK.
- Lamp safety: at no time are both roads non-red. This is a hard invariant.
- ped_pending:
  - Set by ped_req=1 in any cycle.
  - Cleared in the cycle phase becomes PED_WALK.
  - If set and clear coincide, set wins, and the request is serviced next round.
  - ped_req during PED_WALK is latched for the next round.
- Reset values:
  - phase=ALLRED_B, sub-state=LOAD, ped_pending=0, return target=NS.
  - Outputs: ns=100, ew=100, walk=0, tmr_start=1 (LOAD), tmr_duration=T_ALLRED.
  - The first green after reset is NS_GREEN, after T_ALLRED+2 cycles.
- Reset mid-phase: all state returns to the reset values immediately, asynchronously. The timer shares rst, so both restart cleanly.

Optional Feature:
- Macro: TLC_FLASH_EN.
- With the macro defined:
  - The flash_req port is present.
  - If flash_req=1 at a RUN done-seen edge, phase ← FLASH instead of the normal next phase, at a phase boundary only, so the timer sits at 0.
  - In FLASH: tmr_start=0. An internal 8-bit counter toggles both yellow lamps every FLASH_HALF cycles: ns=ew=010 when on, 000 when off, starting on. walk=0.
  - When flash_req=0 is sampled, go to ALLRED_B LOAD on the next edge. ped_pending is preserved.
- Without the macro: no flash_req port, phase 7 is unreachable, and the flash counter is absent.

Test Plan:
- Reset release with defaults → ALLRED_B for 4 cycles, then NS_GREEN for 22 cycles, then NS_YELLOW for 6 cycles, then ALLRED_A for 4 cycles, then EW_GREEN. tmr_duration sequence is 2, 20, 4, 2, 20.
- ped_req pulse during NS_GREEN → after ALLRED_A the phase is PED_WALK (walk=1, 12 cycles), then EW_GREEN. ped_pending is cleared.
- ped_req asserted in the same cycle as entry to PED_WALK → pending stays 1. A second PED_WALK follows ALLRED_B.
- Override T_YELLOW=0 → NS_YELLOW lasts 3 cycles and tmr_duration=1. No hang.
- rst asserted mid EW_GREEN → all outputs return to reset values asynchronously, and the sequence restarts as in the first scenario. Both roads are never non-red in any cycle (assertion checked throughout).
- TLC_FLASH_EN: flash_req=1 during NS_GREEN → FLASH at the phase end, with yellows toggling every 8 cycles and tmr_start=0. On release, ALLRED_B LOAD follows and timer loads 2.
